lfsr_checker: RTL and testbench

- Receive-side companion to the 8-bit shift-left LFSR generator.
- Consumes one LFSR state word per valid cycle, self-synchronises to the sequence, then free-runs its own predictor and counts mismatches.
- Used on loopback and link paths as a PRBS bit-error checker, with lock and error status brought out to debug logic.

---
 rtl/lfsr_checker.sv | 130 +++++++++++++
 tb/tb_lfsr_checker.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_checker.sv
// PRBS receive checker for the 8-bit shift-left LFSR: hunts for a seed, confirms
// LOCK_CNT consecutive matches, then flywheels its own predictor and counts bit errors.
module lfsr_checker #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   TAPS     = 8'hB8,
  parameter int                 LOCK_CNT = 4,
  parameter int                 LOSS_CNT = 3,
  parameter int                 CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             zero_det
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_CNT);

  function automatic logic [WIDTH-1:0] lfsr_nxt(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   expected_q, expected_d;
  logic [3:0]         match_cnt_q, match_cnt_d;
  logic [3:0]         miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic               err_q, err_d;
  logic               zero_det_q, zero_det_d;
  logic               locked_q, locked_d;
  logic               hit;
  logic               count_err;

  always_comb begin
    state_d     = state_q;
    expected_d  = expected_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    err_d       = 1'b0;
    zero_det_d  = 1'b0;
    count_err   = 1'b0;
    hit         = (data_in == expected_q);
    err_count_d = clear_cnt ? '0 : err_count_q;

    if (in_valid) begin
      zero_det_d = (data_in == '0);
      unique case (state_q)
        HUNT: begin
          if (data_in != '0) begin
            expected_d  = lfsr_nxt(data_in);
            match_cnt_d = '0;
            state_d     = SYNC;
          end
        end
        SYNC: begin
          expected_d = lfsr_nxt(data_in);
          if (hit) begin
            match_cnt_d = match_cnt_q + 4'd1;
            if (match_cnt_q + 4'd1 == LOCK_N) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else begin
            match_cnt_d = '0;
            if (data_in == '0) state_d = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction ignores the received word once locked.
          expected_d = lfsr_nxt(expected_q);
          if (hit) begin
            miss_cnt_d = '0;
          end else begin
            err_d      = 1'b1;
            count_err  = 1'b1;
            miss_cnt_d = miss_cnt_q + 4'd1;
            if (miss_cnt_q + 4'd1 == LOSS_N) begin
              state_d     = HUNT;
              match_cnt_d = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // Clear is applied before the increment, so clear+error lands on 1.
    if (count_err) err_count_d = sat_inc(err_count_d);
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      expected_q  <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      err_count_q <= '0;
      err_q       <= 1'b0;
      zero_det_q  <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      expected_q  <= expected_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      err_count_q <= err_count_d;
      err_q       <= err_d;
      zero_det_q  <= zero_det_d;
      locked_q    <= locked_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign zero_det  = zero_det_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default and CNT_W=4/LOSS_CNT=15) checked
// every cycle against a behavioural model, plus directed scenarios with literal expectations.
module tb_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  data_in = 8'h00;
  logic        clear_cnt = 1'b0;

  logic        locked0, err0, zd0;
  logic [15:0] cnt0;
  logic        locked1, err1, zd1;
  logic [3:0]  cnt1;

  always #5 clk = ~clk;

  lfsr_checker u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clear_cnt(clear_cnt),
    .locked(locked0), .err(err0), .err_count(cnt0), .zero_det(zd0)
  );

  lfsr_checker #(.CNT_W(4), .LOSS_CNT(15)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in), .clear_cnt(clear_cnt),
    .locked(locked1), .err(err1), .err_count(cnt1), .zero_det(zd1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int nxt(input int s);
    return ((s << 1) & 8'hFF) | ($countones(s & 8'hB8) & 1);
  endfunction

  // Behavioural model: mode 0=hunt, 1=sync, 2=locked; one copy per instance.
  int m_mode[2], m_exp[2], m_run[2], m_miss[2], m_cnt[2];
  bit m_locked[2], m_err[2], m_zd[2];
  int lossv[2] = '{3, 15};
  int maxv[2]  = '{65535, 15};
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_exp[k] = 0; m_run[k] = 0; m_miss[k] = 0; m_cnt[k] = 0;
        m_locked[k] = 0; m_err[k] = 0; m_zd[k] = 0;
      end else begin
        m_err[k] = 0;
        m_zd[k] = 0;
        if (clear_cnt) m_cnt[k] = 0;
        if (in_valid) begin
          int d;
          d = int'(data_in);
          m_zd[k] = (d == 0);
          if (m_mode[k] == 0) begin
            if (d != 0) begin m_exp[k] = nxt(d); m_run[k] = 0; m_mode[k] = 1; end
          end else if (m_mode[k] == 1) begin
            if (d == m_exp[k]) begin
              m_run[k]++;
              if (m_run[k] == 4) begin m_mode[k] = 2; m_miss[k] = 0; end
            end else begin
              m_run[k] = 0;
              if (d == 0) m_mode[k] = 0;
            end
            m_exp[k] = nxt(d);
          end else begin
            if (d == m_exp[k]) m_miss[k] = 0;
            else begin
              m_err[k] = 1;
              if (m_cnt[k] < maxv[k]) m_cnt[k]++;
              m_miss[k]++;
              if (m_miss[k] == lossv[k]) begin m_mode[k] = 0; m_run[k] = 0; end
            end
            m_exp[k] = nxt(m_exp[k]);
          end
        end
        m_locked[k] = (m_mode[k] == 2);
      end
    end
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("locked0", 32'(locked0), 32'(m_locked[0]));
      chk("err0", 32'(err0), 32'(m_err[0]));
      chk("err_count0", 32'(cnt0), 32'(m_cnt[0]));
      chk("zero_det0", 32'(zd0), 32'(m_zd[0]));
      chk("locked1", 32'(locked1), 32'(m_locked[1]));
      chk("err1", 32'(err1), 32'(m_err[1]));
      chk("err_count1", 32'(cnt1), 32'(m_cnt[1]));
      chk("zero_det1", 32'(zd1), 32'(m_zd[1]));
    end
  end

  int g;

  task automatic send(input int d);
    in_valid = 1'b1;
    data_in  = 8'(d);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
  endtask

  task automatic sendw(input bit corrupt);
    send(corrupt ? (g ^ 8'h5A) : g);
    g = nxt(g);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    do_reset(2);
    chk("rst_locked", 32'(locked0), 0);
    chk("rst_count", 32'(cnt0), 0);

    // Lock on 01,02,04,08,11
    g = 8'h01;
    for (int i = 0; i < 4; i++) begin
      sendw(0);
      chk("lock_early", 32'(locked0), 0);
    end
    chk("chain_08_next", 32'(g), 32'h11);
    sendw(0);
    chk("lock_rise", 32'(locked0), 1);
    chk("lock_cnt0", 32'(cnt0), 0);
    sendw(0);
    chk("chain_47", 32'(g), 32'h47);

    // Single corrupted word: 0x47 sent as 0x46
    send(8'h46); g = nxt(g);
    chk("single_err", 32'(err0), 1);
    chk("single_cnt", 32'(cnt0), 1);
    chk("single_locked", 32'(locked0), 1);
    chk("chain_8e", 32'(g), 32'h8E);
    for (int i = 0; i < 3; i++) begin
      sendw(0);
      chk("flywheel_err", 32'(err0), 0);
    end
    chk("flywheel_cnt", 32'(cnt0), 1);

    // Loss of lock
    clear_cnt = 1'b1; idle(1); clear_cnt = 1'b0;
    chk("clear_only", 32'(cnt0), 0);
    send(8'h00); g = nxt(g);
    chk("loss_zd", 32'(zd0), 1);
    chk("loss_err1", 32'(err0), 1);
    send(8'hFF); g = nxt(g);
    chk("loss_zd2", 32'(zd0), 0);
    chk("loss_locked2", 32'(locked0), 1);
    send(8'h55); g = nxt(g);
    chk("loss_err3", 32'(err0), 1);
    chk("loss_cnt", 32'(cnt0), 3);
    chk("loss_fall", 32'(locked0), 0);
    for (int i = 0; i < 4; i++) begin
      sendw(0);
      chk("relock_early", 32'(locked0), 0);
    end
    sendw(0);
    chk("relock", 32'(locked0), 1);

    // Gapped lock
    do_reset(1);
    g = 8'h01;
    for (int i = 0; i < 5; i++) begin
      chk("gap_before", 32'(locked0), 0);
      sendw(0);
      chk("gap_err", 32'(err0), 0);
      if (i < 4) idle(1 + (i % 3));
    end
    chk("gap_lock", 32'(locked0), 1);

    // Saturation on the 4-bit, loss-15 instance
    for (int i = 0; i < 14; i++) sendw(1);
    sendw(0);
    for (int i = 0; i < 14; i++) sendw(1);
    chk("sat_cnt", 32'(cnt1), 32'hF);
    chk("sat_locked", 32'(locked1), 1);
    clear_cnt = 1'b1;
    sendw(1);
    chk("clear_with_err", 32'(cnt1), 1);

    // Reset while locked
    do_reset(1);
    g = 8'h01;
    for (int i = 0; i < 5; i++) sendw(0);
    for (int i = 0; i < 5; i++) sendw(1);
    chk("midlock_cnt", 32'(cnt1), 5);
    chk("midlock_locked", 32'(locked1), 1);
    do_reset(1);
    chk("rst_mid_locked", 32'(locked1), 0);
    chk("rst_mid_cnt", 32'(cnt1), 0);
    send(8'h00);
    chk("hunt_zd", 32'(zd1), 1);
    g = 8'h01;
    for (int i = 0; i < 4; i++) sendw(0);
    chk("hunt_nolock", 32'(locked1), 0);
    sendw(0);
    chk("hunt_relock", 32'(locked1), 1);

    // Randomised stream with gaps, corruptions, jumps, clears and resets
    g = 8'h01;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      clear_cnt = ($urandom_range(0, 99) < 2);
      if (r < 3) begin
        do_reset(1);
      end else if (r < 250) begin
        idle(1);
      end else begin
        r = $urandom_range(0, 99);
        if (r < 3) send(0);
        else if (r < 12) send($urandom_range(1, 255));
        else send(g);
        g = nxt(g);
        if ($urandom_range(0, 99) == 0) g = $urandom_range(1, 255);
      end
    end

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
